// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and parameter defaults for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_D_BUSY = 2'd1,
    ST_I_BUSY = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_WORD_DEF    = 32'hDEADBEEF;
  localparam int          TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog: counts cycles while en_i, restarts on clr_i, expires when the count reaches TIMEOUT_CYC.
// Latency: expire_o is combinational on the cycle whose increment hits the limit; no backpressure.
module mem_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LIMIT so the counter never wraps back into a false quiet period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_d == LIMIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM data accesses onto one req/ack memory; data wins ties.
// Latency: stall lasts k+1 cycles for an ack at BUSY cycle k; requesters are held off via i_stall_o/d_stall_o.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [DATA_W-1:0] ERR_WORD    = DATA_W'(ERR_WORD_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  input  logic              pipe_stall_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_buf_q, i_buf_d;
  logic [DATA_W-1:0] d_buf_q, d_buf_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic              adv;
  logic              wd_clr, wd_expire;
  logic [DATA_W-1:0] resp_word;

  assign i_stall_o = i_req_i & ~i_done_q;
  assign d_stall_o = d_req_i & ~d_done_q;
  assign adv       = ~(i_stall_o | d_stall_o | pipe_stall_i);
  assign resp_word = mem_ack_i ? mem_rdata_i : ERR_WORD;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_buf_d     = i_buf_q;
    d_buf_d     = d_buf_q;
    i_done_d    = i_done_q;
    d_done_d    = d_done_q;
    err_d       = err_q;
    wd_clr      = 1'b0;

    // Done flags hold off reissue until the whole pipe advances.
    if (adv) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (d_stall_o) begin
          mem_addr_d  = d_addr_i;
          mem_we_d    = d_we_i;
          mem_wdata_d = d_wdata_i;
          state_d     = ST_D_BUSY;
          wd_clr      = 1'b1;
        end else if (i_stall_o) begin
          mem_addr_d = i_addr_i;
          mem_we_d   = 1'b0;
          state_d    = ST_I_BUSY;
          wd_clr     = 1'b1;
        end
      end
      ST_D_BUSY, ST_I_BUSY: begin
        // An ack on the expiry cycle still delivers real data.
        if (mem_ack_i || wd_expire) begin
          if (state_q == ST_D_BUSY) begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_buf_d = resp_word;
          end else begin
            i_done_d = 1'b1;
            i_buf_d  = resp_word;
          end
          if (!mem_ack_i) err_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mem_req_d = (state_d != ST_IDLE);
  end

  mem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .en_i     (state_q != ST_IDLE),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_buf_q     <= '0;
      d_buf_q     <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_buf_q     <= i_buf_d;
      d_buf_q     <= d_buf_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_rdata_o   = i_buf_q;
  assign d_rdata_o   = d_buf_q;
  assign err_o       = err_q;

endmodule
